powlib_pipe_rx: RTL and testbench
=================================

Name: powlib_pipe_rx

Overview:
- Receive-side terminator for a valid-only powlib_pipe link of fixed latency S.
- Issues launch credits to the transmitting side and absorbs every in-flight word into a D-entry buffer.
- Re-presents the data downstream as a ready/valid stream, so a stalled consumer never loses data that was already in the pipe.
- Sits at the far end of any forward-only pipe that feeds backpressured logic.

Parameters:
- W, 8, data width.
- S, 8, latency of the feeding pipe in cycles (informational; sizes the default D).
- D, S+2, buffer depth and total credit count; legal range D >= 1; full throughput requires D >= S+2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- rdy  output  1  credit available; upstream may launch a word into the pipe this cycle
- launch  input  1  upstream launched a word into the pipe this cycle (the pipe's input vld)
- d  input  W  data from pipe output
- vld  input  1  valid from pipe output
- q  output  W  head-of-buffer data
- qvld  output  1  q holds a valid word
- qrdy  input  1  downstream accepts q this cycle
- err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst high at a clock edge):
  - credit counter cr = D; buffer empty; qvld = 0; q = 0; err = 0.
  - rdy is forced 0 while rst is high.
  - Reset mid-operation discards buffered and in-flight accounting with no flush.
  - Words arriving on vld in the cycle after reset are treated as new writes.
- Credit counter:
  - Width clog2(D+1).
  - Combinational signals: rdy = (cr != 0) & ~rst; take = launch & rdy; pop = qvld & qrdy.
  - Update: cr <= cr - take + pop.
  - Simultaneous take and pop leave cr unchanged.
  - cr never exceeds D and never underflows.
- launch while rdy = 0 is a violation: no decrement, err set.
- Buffer:
  - Circular FIFO of D entries, with write pointer, read pointer and occupancy counter; pointers wrap modulo D (D need not be a power of 2).
  - Write on vld. Read on pop.
  - Write and read in the same cycle: occupancy unchanged; both pointers advance.
  - Simultaneous read and write on a single-entry buffer (D = 1) is legal and keeps qvld high with the new word.
- Output:
  - First-word fall-through from registered storage.
  - A word with vld at edge t is visible on q with qvld = 1 after edge t, i.e. 1-cycle latency.
  - qvld = (occupancy != 0).
  - q holds its last value when qvld = 0; it is not required to be zero except after reset.
- Overflow:
  - vld while occupancy == D with no pop in the same cycle drops the word and sets err.
  - With a correct upstream this is unreachable, since credits bound in-flight plus stored words to D.
- Underflow: qrdy while qvld = 0 has no effect.
- err: sticky until rst.
- Invariant (verification assertion): cr + occupancy + words in flight == D every cycle.
- Throughput:
  - With D >= S+2 and qrdy held 1, rdy stays 1 continuously and one word per cycle is sustained.
  - With smaller D, rdy duty-cycles and throughput is D/(S+2) words per cycle.

Test Plan:
- Reset then idle, S=8, D=10 -> rdy=1 from the first cycle after rst drops, qvld=0, cr=10, err=0.
- Stream 0x01..0x20 with launch every cycle, the pipe model delaying 8 cycles, qrdy=1 -> rdy never drops; q emits 0x01..0x20 in order, each 1 cycle after its vld; err=0.
- Same stream with qrdy=0 -> exactly 10 launches accepted, then rdy=0.
  - Buffer fills to 10 words (0x01..0x0A).
  - Raising qrdy for 3 cycles drains 0x01..0x03 and returns 3 credits; rdy reasserts the cycle after the first pop.
- D=1, S=0, alternating qrdy -> at most one word outstanding; simultaneous pop and vld keep qvld=1 with the new data; pointers wrap correctly.
- Forced launch while rdy=0, and forced vld with buffer full and qrdy=0 -> err=1; stored words are unchanged and the extra word is dropped; err stays 1 until rst.
- Assert rst with 5 words buffered and 3 in flight -> after the edge qvld=0, cr=D, err=0; the next arriving vld word appears as the new head.

Source files
------------

// File: rtl/powlib_pipe_rx_if.sv
// Bundle of the upstream credit/pipe signals and the downstream ready/valid
// stream for powlib_pipe_rx. The slave side is the receiver itself; the
// master side is whatever drives the pipe and consumes the stream.
interface powlib_pipe_rx_if #(
   parameter int W = 8
);
   logic         rdy;     // credit available, upstream may launch
   logic         launch;  // upstream launched a word into the pipe
   logic [W-1:0] d;       // pipe output data
   logic         vld;     // pipe output valid
   logic [W-1:0] q;       // head-of-buffer data
   logic         qvld;    // q holds a valid word
   logic         qrdy;    // downstream accepts q
   logic         err;     // sticky protocol-violation flag

   modport master (
      input  rdy, q, qvld, err,
      output launch, d, vld, qrdy
   );

   modport slave (
      output rdy, q, qvld, err,
      input  launch, d, vld, qrdy
   );
endinterface

// File: rtl/powlib_pipe_rx.sv
// Receive-side terminator for a valid-only fixed-latency pipe.
// Hands out D launch credits, catches every in-flight word in a D-entry
// circular buffer and re-presents it as a first-word-fall-through
// ready/valid stream. A credit returns only when the consumer pops a word,
// so stored plus in-flight words can never exceed D.
module powlib_pipe_rx #(
   parameter int W = 8,
   parameter int S = 8,
   parameter int D = S + 2
) (
   input  logic            clk,
   input  logic            rst,
   powlib_pipe_rx_if.slave bus
);

   localparam int CW = $clog2(D + 1);
   localparam int PW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0] D_CNT  = CW'(D);
   localparam logic [PW-1:0] P_LAST = PW'(D - 1);

   if (D < 1 || S < 0) begin : g_bad_params
      $error("powlib_pipe_rx: D must be at least 1 and S non-negative");
   end

   logic [CW-1:0] cr_q, cr_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] rd_ptr_nx_s;
   logic [W-1:0]  q_q, q_d;
   logic          err_q, err_d;
   logic [W-1:0]  mem_q [D];

   logic rdy_s, take_s, pop_s, wr_s, full_s, qvld_s;

   // Pointer increment that wraps at D, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == P_LAST) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   // Handshake decode plus next-state for credits, occupancy, pointers, head and err.
   always_comb begin
      rdy_s       = (cr_q != {CW{1'b0}}) & ~rst;
      take_s      = bus.launch & rdy_s;
      qvld_s      = (occ_q != {CW{1'b0}});
      pop_s       = qvld_s & bus.qrdy;
      full_s      = (occ_q == D_CNT);
      // A full buffer still accepts a word when the head leaves this cycle.
      wr_s        = bus.vld & (~full_s | pop_s);
      rd_ptr_nx_s = ptr_inc(rd_ptr_q);

      cr_d = cr_q;
      if (take_s && !pop_s) begin
         cr_d = cr_q - CW'(1);
      end else if (pop_s && !take_s && (cr_q != D_CNT)) begin
         // Clamped so a misbehaving upstream cannot push credits past D.
         cr_d = cr_q + CW'(1);
      end else begin
         cr_d = cr_q;
      end

      occ_d = occ_q;
      if (wr_s && !pop_s) begin
         occ_d = occ_q + CW'(1);
      end else if (pop_s && !wr_s) begin
         occ_d = occ_q - CW'(1);
      end else begin
         occ_d = occ_q;
      end

      wr_ptr_d = wr_s  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_s ? rd_ptr_nx_s       : rd_ptr_q;

      // Registered head: next stored word on a pop, the incoming word when
      // it becomes the head, otherwise hold the last value.
      q_d = q_q;
      if (pop_s && (occ_q > CW'(1))) begin
         q_d = mem_q[rd_ptr_nx_s];
      end else if (wr_s && (!qvld_s || pop_s)) begin
         q_d = bus.d;
      end else begin
         q_d = q_q;
      end

      err_d = err_q
            | (bus.launch & ~rdy_s)
            | (bus.vld & full_s & ~pop_s);
   end

   // Control and head registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cr_q     <= D_CNT;
         occ_q    <= {CW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         q_q      <= {W{1'b0}};
         err_q    <= 1'b0;
      end else begin
         cr_q     <= cr_d;
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         q_q      <= q_d;
         err_q    <= err_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_s && !rst) begin
         mem_q[wr_ptr_q] <= bus.d;
      end
   end

   assign bus.rdy  = rdy_s;
   assign bus.qvld = qvld_s;
   assign bus.q    = q_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_powlib_pipe_rx.sv
// Directed bench for powlib_pipe_rx: one instance behind an 8-cycle pipe
// model (D=10) and one with a zero-latency pipe and a single entry (D=1).
module tb_powlib_pipe_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   tests = 0;
   int   fails = 0;

   powlib_pipe_rx_if #(.W(8)) ia ();
   powlib_pipe_rx_if #(.W(8)) ib ();

   powlib_pipe_rx #(.W(8), .S(8), .D(10)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   powlib_pipe_rx #(.W(8), .S(0), .D(1))  dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

   // Pipe model for instance A: 8 register stages, not reset.
   logic [7:0] lda;
   logic       nopipe;
   logic       fva;
   logic [7:0] fda;
   logic [7:0] pv = 8'h00;
   logic [7:0] pd [8] = '{default: 8'h00};
   logic       va_e;
   logic [7:0] da_e;

   assign ia.vld = pv[7] | fva;
   assign ia.d   = fva ? fda : pd[7];

   // Instance B sees its launch directly as pipe output (zero latency).
   logic       fvb;
   logic [7:0] fdb;
   logic [7:0] ldb;
   assign ib.vld = ib.launch | fvb;
   assign ib.d   = fvb ? fdb : ldb;

   always @(posedge clk) begin
      pv    <= {pv[6:0], ia.launch & ~nopipe};
      pd[0] <= lda;
      for (int k = 1; k < 8; k++) pd[k] <= pd[k-1];
      va_e  <= ia.vld;
      da_e  <= ia.d;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step;
      step;
      tests++; if (ia.rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy_low_a: got %b want 0", ia.rdy); end
      tests++; if (ib.rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy_low_b: got %b want 0", ib.rdy); end
      rst = 1'b0;
      #1;
      tests++; if (ia.rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy_a: got %b want 1", ia.rdy); end
      tests++; if (ia.qvld !== 1'b0) begin fails++; $display("FAIL reset_qvld_a: got %b want 0", ia.qvld); end
      tests++; if (ia.q !== 8'h00) begin fails++; $display("FAIL reset_q_a: got %h want 00", ia.q); end
      tests++; if (ia.err !== 1'b0) begin fails++; $display("FAIL reset_err_a: got %b want 0", ia.err); end
      tests++; if (ib.rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy_b: got %b want 1", ib.rdy); end
      tests++; if (ib.qvld !== 1'b0) begin fails++; $display("FAIL reset_qvld_b: got %b want 0", ib.qvld); end
   endtask

   task automatic test_stream;
      int sent = 0;
      int exp  = 1;
      ia.qrdy = 1'b1;
      for (int i = 0; i < 48; i++) begin
         tests++; if (ia.qvld !== va_e) begin fails++; $display("FAIL stream_latency: cycle %0d qvld %b want %b", i, ia.qvld, va_e); end
         if (va_e) begin
            tests++; if (ia.q !== 8'(exp)) begin fails++; $display("FAIL stream_data: got %h want %h", ia.q, 8'(exp)); end
            exp++;
         end
         if (sent < 32) begin
            tests++; if (ia.rdy !== 1'b1) begin fails++; $display("FAIL stream_rdy: cycle %0d rdy %b want 1", i, ia.rdy); end
            ia.launch = ia.rdy;
            lda = 8'(sent + 1);
            if (ia.rdy) sent++;
         end else begin
            ia.launch = 1'b0;
         end
         step;
      end
      ia.launch = 1'b0;
      tests++; if (exp !== 33) begin fails++; $display("FAIL stream_count: got %0d words want 32", exp - 1); end
      tests++; if (ia.err !== 1'b0) begin fails++; $display("FAIL stream_err: got %b want 0", ia.err); end
   endtask

   // Launch whenever a credit is offered for n cycles; returns accepted count.
   task automatic fill_a(input int n, input logic [7:0] base, output int acc);
      acc = 0;
      for (int i = 0; i < n; i++) begin
         ia.launch = ia.rdy;
         lda = base + 8'(acc);
         if (ia.rdy) acc++;
         step;
      end
      ia.launch = 1'b0;
   endtask

   task automatic test_fill;
      int acc;
      int exp;
      ia.qrdy = 1'b0;
      fill_a(30, 8'h01, acc);
      tests++; if (acc !== 10) begin fails++; $display("FAIL fill_accepted: got %0d want 10", acc); end
      tests++; if (ia.rdy !== 1'b0) begin fails++; $display("FAIL fill_rdy: got %b want 0", ia.rdy); end
      tests++; if (ia.qvld !== 1'b1) begin fails++; $display("FAIL fill_qvld: got %b want 1", ia.qvld); end
      tests++; if (ia.q !== 8'h01) begin fails++; $display("FAIL fill_head: got %h want 01", ia.q); end
      for (int i = 0; i < 3; i++) begin
         ia.qrdy = 1'b1;
         tests++; if (ia.q !== 8'(i + 1)) begin fails++; $display("FAIL drain3_data: got %h want %h", ia.q, 8'(i + 1)); end
         tests++; if (ia.rdy !== (i != 0)) begin fails++; $display("FAIL drain3_rdy: pop %0d rdy %b want %b", i, ia.rdy, (i != 0)); end
         step;
      end
      ia.qrdy = 1'b0;
      tests++; if (ia.q !== 8'h04) begin fails++; $display("FAIL drain3_head: got %h want 04", ia.q); end
      tests++; if (ia.rdy !== 1'b1) begin fails++; $display("FAIL drain3_rdy_after: got %b want 1", ia.rdy); end
      fill_a(15, 8'h0B, acc);
      tests++; if (acc !== 3) begin fails++; $display("FAIL refill_accepted: got %0d want 3", acc); end
      tests++; if (ia.rdy !== 1'b0) begin fails++; $display("FAIL refill_rdy: got %b want 0", ia.rdy); end
      exp = 4;
      ia.qrdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (ia.qvld) begin
            tests++; if (ia.q !== 8'(exp)) begin fails++; $display("FAIL drain_all_data: got %h want %h", ia.q, 8'(exp)); end
            exp++;
         end
         step;
      end
      ia.qrdy = 1'b0;
      tests++; if (exp !== 14) begin fails++; $display("FAIL drain_all_count: got last %0d want 13", exp - 1); end
      tests++; if (ia.qvld !== 1'b0) begin fails++; $display("FAIL drain_all_qvld: got %b want 0", ia.qvld); end
      tests++; if (ia.err !== 1'b0) begin fails++; $display("FAIL fill_err: got %b want 0", ia.err); end
   endtask

   task automatic test_d1;
      // cycle 0: empty, one credit
      tests++; if (ib.rdy !== 1'b1 || ib.qvld !== 1'b0 || ib.q !== 8'h00) begin fails++; $display("FAIL d1_c0: rdy %b qvld %b q %h want 1 0 00", ib.rdy, ib.qvld, ib.q); end
      ib.launch = 1'b1; ldb = 8'h51; ib.qrdy = 1'b0;
      step;
      tests++; if (ib.rdy !== 1'b0 || ib.qvld !== 1'b1 || ib.q !== 8'h51) begin fails++; $display("FAIL d1_c1: rdy %b qvld %b q %h want 0 1 51", ib.rdy, ib.qvld, ib.q); end
      ib.launch = 1'b0; ib.qrdy = 1'b1;
      step;
      tests++; if (ib.rdy !== 1'b1 || ib.qvld !== 1'b0 || ib.q !== 8'h51) begin fails++; $display("FAIL d1_c2: rdy %b qvld %b q %h want 1 0 51", ib.rdy, ib.qvld, ib.q); end
      ib.launch = 1'b1; ldb = 8'h52; ib.qrdy = 1'b0;
      step;
      tests++; if (ib.rdy !== 1'b0 || ib.qvld !== 1'b1 || ib.q !== 8'h52) begin fails++; $display("FAIL d1_c3: rdy %b qvld %b q %h want 0 1 52", ib.rdy, ib.qvld, ib.q); end
      ib.launch = 1'b0; ib.qrdy = 1'b1; fvb = 1'b1; fdb = 8'h53;
      step;
      fvb = 1'b0;
      tests++; if (ib.rdy !== 1'b1 || ib.qvld !== 1'b1 || ib.q !== 8'h53) begin fails++; $display("FAIL d1_c4: rdy %b qvld %b q %h want 1 1 53", ib.rdy, ib.qvld, ib.q); end
      ib.launch = 1'b1; ldb = 8'h54; ib.qrdy = 1'b1;
      step;
      tests++; if (ib.rdy !== 1'b1 || ib.qvld !== 1'b1 || ib.q !== 8'h54) begin fails++; $display("FAIL d1_c5: rdy %b qvld %b q %h want 1 1 54", ib.rdy, ib.qvld, ib.q); end
      ib.launch = 1'b0; ib.qrdy = 1'b1;
      step;
      ib.qrdy = 1'b0;
      tests++; if (ib.rdy !== 1'b1 || ib.qvld !== 1'b0 || ib.q !== 8'h54) begin fails++; $display("FAIL d1_c6: rdy %b qvld %b q %h want 1 0 54", ib.rdy, ib.qvld, ib.q); end
      tests++; if (ib.err !== 1'b0) begin fails++; $display("FAIL d1_err: got %b want 0", ib.err); end
   endtask

   task automatic test_err;
      int acc;
      int exp;
      ia.qrdy = 1'b0;
      fill_a(30, 8'h21, acc);
      tests++; if (acc !== 10 || ia.err !== 1'b0) begin fails++; $display("FAIL err_prefill: acc %0d err %b want 10 0", acc, ia.err); end
      nopipe = 1'b1; ia.launch = 1'b1;
      step;
      ia.launch = 1'b0; nopipe = 1'b0;
      tests++; if (ia.err !== 1'b1) begin fails++; $display("FAIL err_launch: got %b want 1", ia.err); end
      tests++; if (ia.q !== 8'h21 || ia.qvld !== 1'b1) begin fails++; $display("FAIL err_launch_head: q %h qvld %b want 21 1", ia.q, ia.qvld); end
      step;
      tests++; if (ia.rdy !== 1'b0 || ia.err !== 1'b1) begin fails++; $display("FAIL err_launch_hold: rdy %b err %b want 0 1", ia.rdy, ia.err); end
      rst = 1'b1;
      step;
      rst = 1'b0;
      #1;
      tests++; if (ia.err !== 1'b0 || ia.qvld !== 1'b0 || ia.rdy !== 1'b1) begin fails++; $display("FAIL err_clear: err %b qvld %b rdy %b want 0 0 1", ia.err, ia.qvld, ia.rdy); end
      fill_a(30, 8'h31, acc);
      tests++; if (acc !== 10 || ia.err !== 1'b0) begin fails++; $display("FAIL ovf_prefill: acc %0d err %b want 10 0", acc, ia.err); end
      fva = 1'b1; fda = 8'hEE;
      step;
      fva = 1'b0;
      tests++; if (ia.err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %b want 1", ia.err); end
      exp = 8'h31;
      ia.qrdy = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (ia.qvld) begin
            tests++; if (ia.q !== 8'(exp)) begin fails++; $display("FAIL ovf_data: got %h want %h", ia.q, 8'(exp)); end
            exp++;
         end
         step;
      end
      ia.qrdy = 1'b0;
      tests++; if (exp !== 8'h3B) begin fails++; $display("FAIL ovf_count: got %0d words want 10", exp - 8'h31); end
      tests++; if (ia.err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", ia.err); end
      rst = 1'b1;
      step;
      rst = 1'b0;
      #1;
      tests++; if (ia.err !== 1'b0) begin fails++; $display("FAIL err_rst_clear: got %b want 0", ia.err); end
   endtask

   task automatic test_reset_midop;
      ia.qrdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ia.launch = ia.rdy;
         lda = 8'h41 + 8'(i);
         step;
      end
      ia.launch = 1'b0;
      for (int i = 0; i < 5; i++) step;
      tests++; if (ia.qvld !== 1'b1 || ia.q !== 8'h41) begin fails++; $display("FAIL midop_pre: qvld %b q %h want 1 41", ia.qvld, ia.q); end
      rst = 1'b1;
      step;
      tests++; if (ia.qvld !== 1'b0 || ia.q !== 8'h00 || ia.err !== 1'b0 || ia.rdy !== 1'b0) begin fails++; $display("FAIL midop_rst: qvld %b q %h err %b rdy %b want 0 00 0 0", ia.qvld, ia.q, ia.err, ia.rdy); end
      rst = 1'b0;
      #1;
      tests++; if (ia.rdy !== 1'b1) begin fails++; $display("FAIL midop_rdy: got %b want 1", ia.rdy); end
      step;
      tests++; if (ia.qvld !== 1'b1 || ia.q !== 8'h47) begin fails++; $display("FAIL midop_head: qvld %b q %h want 1 47", ia.qvld, ia.q); end
      ia.qrdy = 1'b1;
      step;
      tests++; if (ia.qvld !== 1'b1 || ia.q !== 8'h48) begin fails++; $display("FAIL midop_next: qvld %b q %h want 1 48", ia.qvld, ia.q); end
      step;
      ia.qrdy = 1'b0;
      tests++; if (ia.qvld !== 1'b0) begin fails++; $display("FAIL midop_empty: qvld %b want 0", ia.qvld); end
   endtask

   initial begin
      rst = 1'b1;
      ia.launch = 1'b0; ia.qrdy = 1'b0;
      ib.launch = 1'b0; ib.qrdy = 1'b0;
      lda = 8'h00; ldb = 8'h00;
      nopipe = 1'b0; fva = 1'b0; fda = 8'h00;
      fvb = 1'b0; fdb = 8'h00;
      test_reset;
      test_stream;
      test_fill;
      test_d1;
      test_err;
      test_reset_midop;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
